// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (IF) and load/store (LS), one transaction at a time.
// Optional build macro ARB_ROUND_ROBIN_EN: on contention, alternate the winner instead of always favouring LS.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [1:0]        ls_size,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;      // 1 = LS owns the port
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              win_ls;
  logic              gnt_now;
  logic              rsp_now;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_owner_q, last_owner_d;
`endif

  // Reset outranks any handshake happening in the same cycle.
  assign gnt_now   = (state_q == REQ)  && mem_ready  && !rst;
  assign rsp_now   = (state_q == WAIT) && mem_rvalid && !rst;
  assign if_gnt    = gnt_now && !owner_q;
  assign ls_gnt    = gnt_now &&  owner_q;
  assign if_rvalid = rsp_now && !owner_q;
  assign ls_rvalid = rsp_now &&  owner_q;
  assign rdata     = rsp_now ? mem_rdata : {DATA_W{1'b0}};

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign busy      = busy_q;
  assign err       = err_q;

  always_comb begin
    if (if_req && ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      win_ls = !last_owner_q;
`else
      win_ls = 1'b1;
`endif
    end else begin
      win_ls = ls_req;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    err_d       = err_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d = gnt_now ? owner_q : last_owner_q;
`endif
    // A response outside WAIT has no owner: flag it and drop it.
    if (mem_rvalid && (state_q != WAIT)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          owner_d     = win_ls;
          mem_req_d   = 1'b1;
          mem_we_d    = win_ls ? ls_we : 1'b0;
          mem_addr_d  = win_ls ? ls_addr : if_addr;
          mem_wdata_d = win_ls ? ls_wdata : {DATA_W{1'b0}};
          mem_size_d  = win_ls ? ls_size : 2'b10;
          state_d     = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_size_q  <= 2'b00;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked by a
// transaction-level reference model and an expected-transaction queue at negedge.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata;
  logic [1:0]  ls_size;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_size(ls_size), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  typedef struct packed {
    logic        owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } txn_t;

  txn_t        exp_q[$];
  logic        gnt_log[$];
  logic [31:0] rsp_log[$];
  int          compared = 0;
  int          mismatched = 0;

  int   m_phase = 0;       // 0 idle, 1 request outstanding, 2 awaiting response
  txn_t m_cur;
  logic m_err = 1'b0;
  logic m_last = 1'b0;     // 1 = LS was granted last

  logic if_gnt_s = 1'b0, ls_gnt_s = 1'b0, acc_s = 1'b0, rsp_s = 1'b0;
  int   if_mode = 0, ls_mode = 0;
  logic auto_mem = 1'b1, rand_lat = 1'b0, use_fixed = 1'b0, pend = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;
  int   rdy_lat = 0, rv_lat = 0, rcnt = 0, wcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare DUT against the model, then advance the model by one cycle.
  always @(negedge clk) begin : mon
    logic exp_ifg, exp_lsg, exp_ifr, exp_lsr;
    txn_t t;
    exp_ifg = (m_phase == 1) && mem_ready  && !rst && !m_cur.owner;
    exp_lsg = (m_phase == 1) && mem_ready  && !rst &&  m_cur.owner;
    exp_ifr = (m_phase == 2) && mem_rvalid && !rst && !m_cur.owner;
    exp_lsr = (m_phase == 2) && mem_rvalid && !rst &&  m_cur.owner;
    chk("if_gnt", {63'd0, if_gnt}, {63'd0, exp_ifg});
    chk("ls_gnt", {63'd0, ls_gnt}, {63'd0, exp_lsg});
    chk("if_rvalid", {63'd0, if_rvalid}, {63'd0, exp_ifr});
    chk("ls_rvalid", {63'd0, ls_rvalid}, {63'd0, exp_lsr});
    chk("rdata", {32'd0, rdata}, (exp_ifr || exp_lsr) ? {32'd0, mem_rdata} : 64'd0);
    chk("busy", {63'd0, busy}, {63'd0, (m_phase != 0)});
    chk("mem_req", {63'd0, mem_req}, {63'd0, (m_phase == 1)});
    chk("err", {63'd0, err}, {63'd0, m_err});
    if (m_phase == 1) begin
      chk("mem_we", {63'd0, mem_we}, {63'd0, m_cur.we});
      chk("mem_addr", {32'd0, mem_addr}, {32'd0, m_cur.addr});
      chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, m_cur.wdata});
      chk("mem_size", {62'd0, mem_size}, {62'd0, m_cur.size});
    end
    if (if_gnt || ls_gnt) begin
      gnt_log.push_back(ls_gnt);
      if (exp_q.size() == 0) begin
        chk("gnt_unexpected", 64'd1, 64'd0);
      end else begin
        t = exp_q.pop_front();
        chk("gnt_owner", {63'd0, ls_gnt}, {63'd0, t.owner});
        chk("gnt_addr", {32'd0, mem_addr}, {32'd0, t.addr});
      end
    end
    if (if_rvalid || ls_rvalid) rsp_log.push_back(rdata);
    if_gnt_s = if_gnt;
    ls_gnt_s = ls_gnt;
    acc_s    = mem_req && mem_ready && !rst;
    rsp_s    = mem_rvalid;
    if (rst) begin
      m_phase = 0;
      m_err   = 1'b0;
      m_last  = 1'b0;
      exp_q.delete();
    end else begin
      if (mem_rvalid && (m_phase != 2)) m_err = 1'b1;
      case (m_phase)
        0: if (if_req || ls_req) begin
`ifdef ARB_ROUND_ROBIN_EN
             t.owner = (if_req && ls_req) ? !m_last : ls_req;
`else
             t.owner = ls_req;
`endif
             t.we    = t.owner ? ls_we : 1'b0;
             t.addr  = t.owner ? ls_addr : if_addr;
             t.wdata = t.owner ? ls_wdata : 32'd0;
             t.size  = t.owner ? ls_size : 2'b10;
             m_cur   = t;
             exp_q.push_back(t);
             m_phase = 1;
           end
        1: if (mem_ready) begin
             m_phase = 2;
             m_last  = m_cur.owner;
           end
        2: if (mem_rvalid) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  task automatic new_if();
    if_req  = 1'b1;
    if_addr = $urandom() & 32'hFFFF_FFFC;
  endtask

  task automatic new_ls();
    ls_req   = 1'b1;
    ls_we    = 1'($urandom_range(1, 0));
    ls_addr  = $urandom();
    ls_wdata = $urandom();
    ls_size  = 2'($urandom_range(2, 0));
  endtask

  // Requester and memory behaviour for one cycle, reacting to handshakes seen at the last negedge.
  task automatic step();
    if (if_gnt_s) begin
      if (if_mode == 1 || (if_mode == 2 && $urandom_range(1, 0) == 1)) new_if();
      else if_req = 1'b0;
    end else if (!if_req && if_mode == 2 && $urandom_range(3, 0) == 0) new_if();
    if (ls_gnt_s) begin
      if (ls_mode == 1 || (ls_mode == 2 && $urandom_range(1, 0) == 1)) new_ls();
      else ls_req = 1'b0;
    end else if (!ls_req && ls_mode == 2 && $urandom_range(3, 0) == 0) new_ls();
    if (auto_mem) begin
      if (acc_s) begin
        pend = 1'b1;
        wcnt = 0;
        if (rand_lat) rv_lat = $urandom_range(3, 0);
      end else if (rsp_s) pend = 1'b0;
      if (mem_req) begin
        mem_ready = (rcnt >= rdy_lat);
        rcnt++;
      end else begin
        mem_ready = 1'b0;
        rcnt = 0;
        if (rand_lat) rdy_lat = $urandom_range(3, 0);
      end
      mem_rvalid = pend && (wcnt >= rv_lat);
      wcnt++;
      mem_rdata = use_fixed ? fixed_rdata : $urandom();
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_wdata = 32'd0; ls_size = 2'b00;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    chk("rst_mem_size", {62'd0, mem_size}, 64'd0);
    chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fetch alone, immediate memory
    use_fixed = 1'b1; fixed_rdata = 32'h0000_0013;
    if_req = 1'b1; if_addr = 32'h100;
    run(6);
    chk("if_alone_gnts", gnt_log.size(), 64'd1);
    chk("if_alone_rdata", rsp_log.size() > 0 ? {32'd0, rsp_log[0]} : 64'hDEAD, 64'h13);
    gnt_log.delete(); rsp_log.delete();
    use_fixed = 1'b0;

    // Store with two stall cycles of mem_ready
    rdy_lat = 2;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF; ls_size = 2'b01;
    run(9);
    chk("store_gnt_owner", gnt_log.size() == 1 ? {63'd0, gnt_log[0]} : 64'hF, 64'd1);
    chk("store_rsp_count", rsp_log.size(), 64'd1);
    rdy_lat = 0;

    // Contention from reset: four back-to-back transactions
    rst = 1'b1; run(2); rst = 1'b0;
    gnt_log.delete();
    if_mode = 1; ls_mode = 1;
    new_if(); new_ls();
    run(12);
    chk("contend_count", {63'd0, (gnt_log.size() >= 4)}, 64'd1);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      chk("contend_owner", {63'd0, gnt_log[i]}, {63'd0, (i % 2 == 0)});
`else
      chk("contend_owner", {63'd0, gnt_log[i]}, 64'd1);
`endif
    end
    if_mode = 0; ls_mode = 0;
    run(30);

    // Spurious response in IDLE
    auto_mem = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    run(1);
    mem_rvalid = 1'b0;
    run(4);
    chk("spurious_err_sticky", {63'd0, err}, 64'd1);
    rst = 1'b1; run(1); rst = 1'b0; run(1);
    chk("err_cleared", {63'd0, err}, 64'd0);
    auto_mem = 1'b1;

    // Reset while waiting for a response; the late response is spurious
    rv_lat = 3;
    new_if();
    run(3);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(5);
    chk("late_rsp_err", {63'd0, err}, 64'd1);
    rst = 1'b1; run(1); rst = 1'b0;
    rv_lat = 0;

    // Random traffic with random stalls
    rand_lat = 1'b1;
    if_mode = 2; ls_mode = 2;
    run(600);
    if_mode = 0; ls_mode = 0;
    run(60);
    chk("drain_queue_empty", exp_q.size(), 64'd0);
    chk("drain_idle", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
